// File: rtl/video_mode_pkg.sv
// Shared video-mode types and default detector thresholds (also used by the scaler top).
package video_mode_pkg;

    typedef enum logic [1:0] {
        MODE_NONE   = 2'd0,
        MODE_PAL50  = 2'd1,
        MODE_NTSC60 = 2'd2,
        MODE_VGA    = 2'd3
    } mode_t;

    typedef enum logic {
        S_SEARCH  = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

    localparam int unsigned DEF_FRAME_CNT_W     = 22;
    localparam int unsigned DEF_LINE_CNT_W      = 11;
    localparam int unsigned DEF_THRESH_55HZ     = 1350000;
    localparam int unsigned DEF_TIMEOUT_CLKS    = 3000000;
    localparam int unsigned DEF_VGA_LINE_MIN    = 400;
    localparam int unsigned DEF_MIN_LINES       = 200;
    localparam int unsigned DEF_STABLE_FRAMES   = 3;
    localparam bit          DEF_SYNC_ACTIVE_LOW = 1'b1;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for a raw sync input followed by a registered leading-edge pulse.
module sync_edge_detect #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sync,
    output logic o_edge
);

    logic [1:0] meta_q, meta_d;
    logic       last_q, last_d;
    logic       edge_q, edge_d;

    // Sync is normalised to active-high at the first flop so reset (all zeros) means idle.
    always_comb begin
        meta_d = {meta_q[0], i_sync ^ ACTIVE_LOW};
        last_d = meta_q[1];
        edge_d = meta_q[1] & ~last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            last_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            last_q <= last_d;
            edge_q <= edge_d;
        end
    end

    assign o_edge = edge_q;

endmodule

// File: rtl/video_mode_detect.sv
// Measures frame period / line count of the raw PAL/Amiga syncs and commits a
// hysteresis-filtered video mode with loss-of-signal timeout.
module video_mode_detect
    import video_mode_pkg::*;
#(
    parameter int unsigned FRAME_CNT_W     = DEF_FRAME_CNT_W,
    parameter int unsigned LINE_CNT_W      = DEF_LINE_CNT_W,
    parameter int unsigned THRESH_55HZ     = DEF_THRESH_55HZ,
    parameter int unsigned TIMEOUT_CLKS    = DEF_TIMEOUT_CLKS,
    parameter int unsigned VGA_LINE_MIN    = DEF_VGA_LINE_MIN,
    parameter int unsigned MIN_LINES       = DEF_MIN_LINES,
    parameter int unsigned STABLE_FRAMES   = DEF_STABLE_FRAMES,
    parameter bit          SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_pal_hsync,
    input  logic                   i_pal_vsync,
    output logic [1:0]             o_mode,
    output logic                   o_valid,
    output logic                   o_50hz,
    output logic                   o_passthrough,
    output logic                   o_mode_change,
    output logic [LINE_CNT_W-1:0]  o_lines,
    output logic [FRAME_CNT_W-1:0] o_frame_clks,
    output logic                   o_meas_strobe
);

    localparam int unsigned STB_W = $clog2(STABLE_FRAMES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [FRAME_CNT_W-1:0] FRAME_MAX = '1;
    localparam logic [LINE_CNT_W-1:0]  LINE_MAX  = '1;
    localparam logic [FRAME_CNT_W-1:0] THRESH_F  = FRAME_CNT_W'(THRESH_55HZ);
    localparam logic [LINE_CNT_W-1:0]  VGA_L     = LINE_CNT_W'(VGA_LINE_MIN);
    localparam logic [LINE_CNT_W-1:0]  MIN_L     = LINE_CNT_W'(MIN_LINES);
    localparam logic [STB_W-1:0]       STB_MAX   = STB_W'(STABLE_FRAMES);
    localparam logic [TMO_W-1:0]       TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);

    logic hs_edge, vs_edge;

    sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hs_sync (
        .clk    (clk),
        .rst    (reset),
        .i_sync (i_pal_hsync),
        .o_edge (hs_edge)
    );

    sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vs_sync (
        .clk    (clk),
        .rst    (reset),
        .i_sync (i_pal_vsync),
        .o_edge (vs_edge)
    );

    state_t                 state_q, state_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [LINE_CNT_W-1:0]  line_cnt_q, line_cnt_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    mode_t                  cand_q, cand_d;
    logic [STB_W-1:0]       stable_q, stable_d;
    mode_t                  mode_q, mode_d;
    logic                   valid_q, valid_d;
    logic                   hz50_q, hz50_d;
    logic                   pass_q, pass_d;
    logic                   change_q, change_d;
    logic [LINE_CNT_W-1:0]  lines_q, lines_d;
    logic [FRAME_CNT_W-1:0] fclks_q, fclks_d;
    logic                   strobe_q, strobe_d;
    mode_t                  cand_new;
    logic                   timeout;

    function automatic mode_t classify(input logic [LINE_CNT_W-1:0]  lines,
                                       input logic [FRAME_CNT_W-1:0] clks);
        if (lines < MIN_L || clks == FRAME_MAX) return MODE_NONE;
        if (lines > VGA_L)                      return MODE_VGA;
        if (clks >= THRESH_F)                   return MODE_PAL50;
        return MODE_NTSC60;
    endfunction

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        line_cnt_d  = line_cnt_q;
        cand_d      = cand_q;
        stable_d    = stable_q;
        mode_d      = mode_q;
        lines_d     = lines_q;
        fclks_d     = fclks_q;
        change_d    = 1'b0;
        strobe_d    = 1'b0;
        cand_new    = MODE_NONE;

        // A vsync edge on the expiry clock suppresses the timeout.
        timeout = !vs_edge && (tmo_q == TMO_LAST);
        if (vs_edge || timeout) tmo_d = '0;
        else                    tmo_d = tmo_q + 1'b1;

        unique case (state_q)
            S_SEARCH: begin
                frame_cnt_d = '0;
                line_cnt_d  = '0;
                if (vs_edge) begin
                    state_d     = S_MEASURE;
                    frame_cnt_d = FRAME_CNT_W'(1);
                end
            end
            S_MEASURE: begin
                if (frame_cnt_q != FRAME_MAX) frame_cnt_d = frame_cnt_q + 1'b1;
                if (hs_edge && line_cnt_q != LINE_MAX) line_cnt_d = line_cnt_q + 1'b1;
                if (vs_edge) begin
                    lines_d     = line_cnt_q;
                    fclks_d     = frame_cnt_q;
                    strobe_d    = 1'b1;
                    frame_cnt_d = FRAME_CNT_W'(1);
                    line_cnt_d  = LINE_CNT_W'(hs_edge);
                    cand_new    = classify(line_cnt_q, frame_cnt_q);
                    if (cand_new != cand_q)     stable_d = STB_W'(1);
                    else if (stable_q != STB_MAX) stable_d = stable_q + 1'b1;
                    cand_d = cand_new;
                    if (stable_d == STB_MAX && cand_new != mode_q) begin
                        mode_d   = cand_new;
                        change_d = 1'b1;
                    end
                end
            end
            default: state_d = S_SEARCH;
        endcase

        if (timeout) begin
            state_d     = S_SEARCH;
            frame_cnt_d = '0;
            line_cnt_d  = '0;
            cand_d      = MODE_NONE;
            stable_d    = '0;
            lines_d     = '0;
            fclks_d     = '0;
            if (mode_q != MODE_NONE) begin
                mode_d   = MODE_NONE;
                change_d = 1'b1;
            end
        end

        valid_d = (mode_d != MODE_NONE);
        hz50_d  = (mode_d == MODE_PAL50);
        pass_d  = (mode_d == MODE_VGA);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_SEARCH;
            frame_cnt_q <= '0;
            line_cnt_q  <= '0;
            tmo_q       <= '0;
            cand_q      <= MODE_NONE;
            stable_q    <= '0;
            mode_q      <= MODE_NONE;
            valid_q     <= 1'b0;
            hz50_q      <= 1'b0;
            pass_q      <= 1'b0;
            change_q    <= 1'b0;
            lines_q     <= '0;
            fclks_q     <= '0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            line_cnt_q  <= line_cnt_d;
            tmo_q       <= tmo_d;
            cand_q      <= cand_d;
            stable_q    <= stable_d;
            mode_q      <= mode_d;
            valid_q     <= valid_d;
            hz50_q      <= hz50_d;
            pass_q      <= pass_d;
            change_q    <= change_d;
            lines_q     <= lines_d;
            fclks_q     <= fclks_d;
            strobe_q    <= strobe_d;
        end
    end

    assign o_mode        = mode_q;
    assign o_valid       = valid_q;
    assign o_50hz        = hz50_q;
    assign o_passthrough = pass_q;
    assign o_mode_change = change_q;
    assign o_lines       = lines_q;
    assign o_frame_clks  = fclks_q;
    assign o_meas_strobe = strobe_q;

endmodule
